mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and writeback. Non-memory results pass through with one cycle of latency. Loads and stores run on a req/gnt/rvalid data-memory bus under a three-state FSM, which applies byte-lane steering, byte enables and load sign/zero extension. While an access is in flight, the stage raises a stall to the pipeline controller.

---
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if: data-memory bus between mem_stage and the data memory.
//
// Handshake: a request is offered by holding dmem_req_o high with stable
// dmem_we_o/addr/be/wdata; the transfer is accepted in the cycle where
// dmem_req_o && dmem_gnt_i. For reads, dmem_rvalid_i later marks the single
// cycle in which dmem_rdata_i is valid (never in the grant cycle itself).
//
// Signals:
//   dmem_req_o     stage -> mem  request
//   dmem_we_o      stage -> mem  1 = write
//   dmem_addr_o    stage -> mem  word-aligned address
//   dmem_be_o      stage -> mem  byte enables
//   dmem_wdata_o   stage -> mem  lane-steered write data
//   dmem_gnt_i     mem -> stage  request accepted this cycle
//   dmem_rvalid_i  mem -> stage  read data valid this cycle
//   dmem_rdata_i   mem -> stage  read data
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory-access pipeline stage between execute and writeback.
//
// Non-memory results pass to writeback with one cycle of latency. Loads and
// stores are issued on the dmem bus by an IDLE/REQ/WAIT FSM with byte-lane
// steering, byte enables and load sign/zero extension. While an access is in
// flight stall_mem_o is high and the execute-side inputs are ignored.
//
// Ports:
//   clk, rstl                clock, asynchronous active-low reset
//   opcode/rd/rd_data_exe_2_mem_i, mem_data_i, load_valid_i, store_valid_i
//                            operation from execute (rd_data = address for
//                            loads/stores, mem_data = right-aligned store data)
//   dmem                     data-memory bus (mem_stage_if.master)
//   opcode/rd/rd_data_mem_2_wb_o, wb_valid_o
//                            result to writeback, valid one cycle per instr
//   misalign_o               one-cycle pulse: misaligned access dropped
//   stall_mem_o              stage busy; upstream must freeze
//   state_dbg_o              current FSM state (0 IDLE, 1 REQ, 2 WAIT)
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic               clk,
  input  logic               rstl,
  input  logic [10:0]        opcode_exe_2_mem_i,
  input  logic [4:0]         rd_exe_2_mem_i,
  input  logic [31:0]        rd_data_exe_2_mem_i,
  input  logic [31:0]        mem_data_i,
  input  logic               load_valid_i,
  input  logic               store_valid_i,
  mem_stage_if.master        dmem,
  output logic [10:0]        opcode_mem_2_wb_o,
  output logic [4:0]         rd_mem_2_wb_o,
  output logic [31:0]        rd_data_mem_2_wb_o,
  output logic               wb_valid_o,
  output logic               misalign_o,
  output logic               stall_mem_o,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Decode of the incoming operation
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic        is_load, is_store, is_mem;
  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        capture;

  // Transaction held stable through REQ/WAIT
  logic [29:0] word_addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [10:0] op_q;

  logic        busy;
  logic [31:0] byte_sel, half_sel;
  logic [31:0] load_result;

  assign funct3_in = opcode_exe_2_mem_i[9:7];
  assign addr_in   = rd_data_exe_2_mem_i;
  // Load wins if both strobes are (illegally) high.
  assign is_load   = load_valid_i;
  assign is_store  = store_valid_i & ~load_valid_i;
  assign is_mem    = is_load | is_store;

  // funct3[1:0]: 00 byte, 01 half, 10 word
  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = mem_data_i;
    case (funct3_in[1:0])
      2'b00: begin
        be_in    = 4'b0001 << addr_in[1:0];
        wdata_in = {4{mem_data_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_in[0];
        be_in      = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{mem_data_i[15:0]}};
      end
      default: begin
        misaligned = (addr_in[1:0] != 2'b00);
        be_in      = 4'b1111;
        wdata_in   = mem_data_i;
      end
    endcase
    if (!is_store) begin
      wdata_in = 32'h0;
    end
  end

  assign capture = (state_q == IDLE) && is_mem && !misaligned;

  // FSM state register
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stores finish at grant, loads wait for rvalid
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = REQ;
      REQ:     if (dmem.dmem_gnt_i) state_d = we_q ? IDLE : WAIT;
      WAIT:    if (dmem.dmem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend
  assign byte_sel = dmem.dmem_rdata_i >> {off_q, 3'b000};
  assign half_sel = dmem.dmem_rdata_i >> {off_q[1], 4'b0000};

  always_comb begin
    load_result = dmem.dmem_rdata_i;
    case (op_q[9:7])
      3'b000:  load_result = {{24{byte_sel[7]}}, byte_sel[7:0]};
      3'b001:  load_result = {{16{half_sel[15]}}, half_sel[15:0]};
      3'b100:  load_result = {24'h0, byte_sel[7:0]};
      3'b101:  load_result = {16'h0, half_sel[15:0]};
      default: load_result = dmem.dmem_rdata_i;
    endcase
  end

  // Transaction capture
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      word_addr_q <= 30'h0;
      off_q       <= 2'b00;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      rd_q        <= 5'h0;
      op_q        <= 11'h0;
    end else if (capture) begin
      word_addr_q <= addr_in[31:2];
      off_q       <= addr_in[1:0];
      be_q        <= be_in;
      wdata_q     <= wdata_in;
      we_q        <= is_store;
      rd_q        <= rd_exe_2_mem_i;
      op_q        <= opcode_exe_2_mem_i;
    end
  end

  // Writeback outputs; wb_valid_o and misalign_o are single-cycle pulses
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      opcode_mem_2_wb_o  <= 11'h0;
      rd_mem_2_wb_o      <= 5'h0;
      rd_data_mem_2_wb_o <= 32'h0;
      wb_valid_o         <= 1'b0;
      misalign_o         <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            if (misaligned) begin
              // Dropped access still retires so the pipeline sees it once
              opcode_mem_2_wb_o  <= opcode_exe_2_mem_i;
              rd_mem_2_wb_o      <= 5'h0;
              rd_data_mem_2_wb_o <= 32'h0;
              wb_valid_o         <= 1'b1;
              misalign_o         <= 1'b1;
            end
          end else begin
            opcode_mem_2_wb_o  <= opcode_exe_2_mem_i;
            rd_mem_2_wb_o      <= rd_exe_2_mem_i;
            rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
            wb_valid_o         <= (opcode_exe_2_mem_i != 11'h0);
          end
        end
        REQ: begin
          if (dmem.dmem_gnt_i && we_q) begin
            opcode_mem_2_wb_o  <= op_q;
            rd_mem_2_wb_o      <= 5'h0;
            rd_data_mem_2_wb_o <= 32'h0;
            wb_valid_o         <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid_i) begin
            opcode_mem_2_wb_o  <= op_q;
            rd_mem_2_wb_o      <= rd_q;
            rd_data_mem_2_wb_o <= load_result;
            wb_valid_o         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs come straight from state so reset drops them immediately;
  // the latched transaction is only shown while busy.
  assign busy              = (state_q != IDLE);
  assign dmem.dmem_req_o   = (state_q == REQ);
  assign dmem.dmem_we_o    = busy & we_q;
  assign dmem.dmem_addr_o  = busy ? {word_addr_q, 2'b00} : 32'h0;
  assign dmem.dmem_be_o    = busy ? be_q : 4'h0;
  assign dmem.dmem_wdata_o = busy ? wdata_q : 32'h0;
  assign stall_mem_o       = busy;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed bench for mem_stage. Inputs change 1 time unit after
// the rising edge; results are checked there and by a writeback monitor on
// the falling edge against an expected queue of {opcode, rd, data}.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [10:0] OP_ADD = 11'h033;
  localparam logic [10:0] OP_LB  = 11'h003;
  localparam logic [10:0] OP_LH  = 11'h083;
  localparam logic [10:0] OP_LW  = 11'h103;
  localparam logic [10:0] OP_LBU = 11'h203;
  localparam logic [10:0] OP_LHU = 11'h283;
  localparam logic [10:0] OP_SB  = 11'h023;
  localparam logic [10:0] OP_SH  = 11'h0A3;
  localparam logic [10:0] OP_SW  = 11'h123;

  logic        clk = 1'b0;
  logic        rstl;
  logic [10:0] opcode_exe_2_mem_i;
  logic [4:0]  rd_exe_2_mem_i;
  logic [31:0] rd_data_exe_2_mem_i;
  logic [31:0] mem_data_i;
  logic        load_valid_i;
  logic        store_valid_i;
  logic [10:0] opcode_mem_2_wb_o;
  logic [4:0]  rd_mem_2_wb_o;
  logic [31:0] rd_data_mem_2_wb_o;
  logic        wb_valid_o;
  logic        misalign_o;
  logic        stall_mem_o;
  logic [1:0]  state_dbg_o;

  mem_stage_if dmem_bus();

  int checks = 0;
  int failures = 0;
  int wb_count = 0;
  logic [47:0] exp_q[$];

  mem_stage dut (
    .clk                 (clk),
    .rstl                (rstl),
    .opcode_exe_2_mem_i  (opcode_exe_2_mem_i),
    .rd_exe_2_mem_i      (rd_exe_2_mem_i),
    .rd_data_exe_2_mem_i (rd_data_exe_2_mem_i),
    .mem_data_i          (mem_data_i),
    .load_valid_i        (load_valid_i),
    .store_valid_i       (store_valid_i),
    .dmem                (dmem_bus),
    .opcode_mem_2_wb_o   (opcode_mem_2_wb_o),
    .rd_mem_2_wb_o       (rd_mem_2_wb_o),
    .rd_data_mem_2_wb_o  (rd_data_mem_2_wb_o),
    .wb_valid_o          (wb_valid_o),
    .misalign_o          (misalign_o),
    .stall_mem_o         (stall_mem_o),
    .state_dbg_o         (state_dbg_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // Checking helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writeback monitor / scoreboard
  always @(negedge clk) begin
    if (rstl === 1'b1 && wb_valid_o === 1'b1) begin
      wb_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_wb observed=%h/%h/%h expected=no_writeback",
               opcode_mem_2_wb_o, rd_mem_2_wb_o, rd_data_mem_2_wb_o);
      end
      if (exp_q.size() != 0) begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("wb_opcode", 32'(opcode_mem_2_wb_o), 32'(e[47:37]));
        chk("wb_rd", 32'(rd_mem_2_wb_o), 32'(e[36:32]));
        chk("wb_data", rd_data_mem_2_wb_o, e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] op, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] md, input logic ld, input logic st);
    opcode_exe_2_mem_i  = op;
    rd_exe_2_mem_i      = rd;
    rd_data_exe_2_mem_i = data;
    mem_data_i          = md;
    load_valid_i        = ld;
    store_valid_i       = st;
  endtask

  task automatic idle_inputs();
    drive(11'h0, 5'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One load or store through the bus; gnt_wait REQ cycles without grant
  // (with a stray rvalid that must be ignored), rv_wait WAIT cycles without
  // rvalid. Ends in the completion cycle.
  task automatic run_mem(input logic [10:0] op, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] md, input logic ld, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    drive(op, rd, addr, md, ld, !ld);
    tick();
    idle_inputs();
    chk("bus_addr", dmem_bus.dmem_addr_o, {addr[31:2], 2'b00});
    chk("bus_be", 32'(dmem_bus.dmem_be_o), 32'(exp_be));
    chk("bus_wdata", dmem_bus.dmem_wdata_o, exp_wdata);
    chk("bus_we", 32'(dmem_bus.dmem_we_o), 32'(!ld));
    chk("stall_req", 32'(stall_mem_o), 32'd1);
    for (int i = 0; i < gnt_wait; i++) begin
      chk("req_hold", 32'(dmem_bus.dmem_req_o), 32'd1);
      dmem_bus.dmem_rvalid_i = 1'b1;
      dmem_bus.dmem_rdata_i  = 32'hFFFF_FFFF;
      tick();
      dmem_bus.dmem_rvalid_i = 1'b0;
      dmem_bus.dmem_rdata_i  = 32'h0;
    end
    chk("req_at_gnt", 32'(dmem_bus.dmem_req_o), 32'd1);
    chk("state_req", 32'(state_dbg_o), 32'd1);
    dmem_bus.dmem_gnt_i = 1'b1;
    tick();
    dmem_bus.dmem_gnt_i = 1'b0;
    if (ld) begin
      chk("req_drop", 32'(dmem_bus.dmem_req_o), 32'd0);
      for (int i = 0; i < rv_wait; i++) begin
        chk("stall_wait", 32'(stall_mem_o), 32'd1);
        tick();
      end
      chk("stall_rvalid", 32'(stall_mem_o), 32'd1);
      chk("addr_held", dmem_bus.dmem_addr_o, {addr[31:2], 2'b00});
      dmem_bus.dmem_rvalid_i = 1'b1;
      dmem_bus.dmem_rdata_i  = rdata;
      tick();
      dmem_bus.dmem_rvalid_i = 1'b0;
      dmem_bus.dmem_rdata_i  = 32'h0;
    end
    chk("done_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("done_stall", 32'(stall_mem_o), 32'd0);
    chk("done_req", 32'(dmem_bus.dmem_req_o), 32'd0);
  endtask

  task automatic misalign_case(input logic [10:0] op, input logic [31:0] addr, input logic ld);
    exp_q.push_back({op, 5'd0, 32'h0});
    drive(op, 5'd9, addr, 32'h1111_2222, ld, !ld);
    tick();
    idle_inputs();
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("mis_req", 32'(dmem_bus.dmem_req_o), 32'd0);
    chk("mis_stall", 32'(stall_mem_o), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misalign_o), 32'd0);
    chk("mis_wb_end", 32'(wb_valid_o), 32'd0);
  endtask

  // Directed sequence
  initial begin
    int base;
    rstl = 1'b0;
    idle_inputs();
    dmem_bus.dmem_gnt_i    = 1'b0;
    dmem_bus.dmem_rvalid_i = 1'b0;
    dmem_bus.dmem_rdata_i  = 32'h0;
    repeat (3) tick();

    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_req", 32'(dmem_bus.dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_mem_o), 32'd0);
    chk("rst_data", rd_data_mem_2_wb_o, 32'h0);
    chk("rst_be", 32'(dmem_bus.dmem_be_o), 32'd0);
    chk("rst_state", 32'(state_dbg_o), 32'd0);
    rstl = 1'b1;
    tick();

    // ADD passes through in cycle 1
    exp_q.push_back({OP_ADD, 5'd3, 32'h5});
    drive(OP_ADD, 5'd3, 32'h0000_0005, 32'h0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("add_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("add_rd", 32'(rd_mem_2_wb_o), 32'd3);
    chk("add_data", rd_data_mem_2_wb_o, 32'h5);
    chk("add_stall", 32'(stall_mem_o), 32'd0);
    tick();
    chk("bubble_wb_valid", 32'(wb_valid_o), 32'd0);

    // SB, immediate grant
    exp_q.push_back({OP_SB, 5'd0, 32'h0});
    run_mem(OP_SB, 5'd4, 32'h1000_0002, 32'h0000_00A5, 1'b0, 0, 0, 32'h0,
            4'b0100, 32'hA5A5_A5A5);

    // LB / LBU at byte 3, grant delayed 2 cycles, rvalid right after grant
    exp_q.push_back({OP_LB, 5'd7, 32'hFFFF_FF80});
    run_mem(OP_LB, 5'd7, 32'h2000_0003, 32'h0, 1'b1, 2, 0, 32'h8012_3456, 4'b1000, 32'h0);
    exp_q.push_back({OP_LBU, 5'd7, 32'h0000_0080});
    run_mem(OP_LBU, 5'd7, 32'h2000_0003, 32'h0, 1'b1, 2, 0, 32'h8012_3456, 4'b1000, 32'h0);

    // LH upper half with one rvalid wait cycle; LHU lower half
    exp_q.push_back({OP_LH, 5'd8, 32'hFFFF_8001});
    run_mem(OP_LH, 5'd8, 32'h2000_0002, 32'h0, 1'b1, 0, 1, 32'h8001_7FFF, 4'b1100, 32'h0);
    exp_q.push_back({OP_LHU, 5'd8, 32'h0000_7FFF});
    run_mem(OP_LHU, 5'd8, 32'h2000_0000, 32'h0, 1'b1, 0, 0, 32'h8001_7FFF, 4'b0011, 32'h0);

    // SH upper half with one grant wait
    exp_q.push_back({OP_SH, 5'd0, 32'h0});
    run_mem(OP_SH, 5'd2, 32'h3000_0002, 32'h0000_1234, 1'b0, 1, 0, 32'h0,
            4'b1100, 32'h1234_1234);

    // Misaligned accesses are dropped
    misalign_case(OP_LW, 32'h3000_0001, 1'b1);
    misalign_case(OP_SH, 32'h3000_0003, 1'b0);

    // LW followed by an ADD held upstream during the stall
    base = wb_count;
    exp_q.push_back({OP_LW, 5'd5, 32'hDEAD_BEEF});
    exp_q.push_back({OP_ADD, 5'd6, 32'h77});
    drive(OP_LW, 5'd5, 32'h4000_0004, 32'h0, 1'b1, 1'b0);
    tick();
    drive(OP_ADD, 5'd6, 32'h77, 32'h0, 1'b0, 1'b0);
    dmem_bus.dmem_gnt_i = 1'b1;
    chk("b2b_stall1", 32'(stall_mem_o), 32'd1);
    tick();
    dmem_bus.dmem_gnt_i    = 1'b0;
    dmem_bus.dmem_rvalid_i = 1'b1;
    dmem_bus.dmem_rdata_i  = 32'hDEAD_BEEF;
    chk("b2b_stall2", 32'(stall_mem_o), 32'd1);
    chk("b2b_no_leak", 32'(wb_valid_o), 32'd0);
    tick();
    dmem_bus.dmem_rvalid_i = 1'b0;
    dmem_bus.dmem_rdata_i  = 32'h0;
    chk("b2b_lw_valid", 32'(wb_valid_o), 32'd1);
    chk("b2b_lw_data", rd_data_mem_2_wb_o, 32'hDEAD_BEEF);
    chk("b2b_stall3", 32'(stall_mem_o), 32'd0);
    tick();
    idle_inputs();
    chk("b2b_add_valid", 32'(wb_valid_o), 32'd1);
    chk("b2b_add_rd", 32'(rd_mem_2_wb_o), 32'd6);
    tick();
    chk("b2b_end", 32'(wb_valid_o), 32'd0);
    chk("b2b_pulses", 32'(wb_count - base), 32'd2);

    // Reset while waiting for read data
    drive(OP_LW, 5'd9, 32'h5000_0000, 32'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    dmem_bus.dmem_gnt_i = 1'b1;
    tick();
    dmem_bus.dmem_gnt_i = 1'b0;
    chk("rstw_state", 32'(state_dbg_o), 32'd2);
    rstl = 1'b0;
    #1;
    chk("rstw_req", 32'(dmem_bus.dmem_req_o), 32'd0);
    chk("rstw_stall", 32'(stall_mem_o), 32'd0);
    chk("rstw_addr", dmem_bus.dmem_addr_o, 32'h0);
    chk("rstw_wb_data", rd_data_mem_2_wb_o, 32'h0);
    chk("rstw_wb_op", 32'(opcode_mem_2_wb_o), 32'd0);
    chk("rstw_state0", 32'(state_dbg_o), 32'd0);
    tick();
    rstl = 1'b1;
    tick();
    dmem_bus.dmem_rvalid_i = 1'b1;
    dmem_bus.dmem_rdata_i  = 32'h1234_5678;
    tick();
    dmem_bus.dmem_rvalid_i = 1'b0;
    dmem_bus.dmem_rdata_i  = 32'h0;
    chk("late_rvalid_wb", 32'(wb_valid_o), 32'd0);
    chk("late_rvalid_stall", 32'(stall_mem_o), 32'd0);

    // Fresh SW after reset
    exp_q.push_back({OP_SW, 5'd0, 32'h0});
    run_mem(OP_SW, 5'd1, 32'h6000_0008, 32'hCAFE_F00D, 1'b0, 0, 0, 32'h0,
            4'b1111, 32'hCAFE_F00D);

    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
